instruction_dump_tx: RTL

INSTRUCTION_DUMP_TX -- requirements
Module: instruction_dump_tx

---
 rtl/instruction_dump_tx_pkg.sv | 27 ++
 rtl/txuartlite.sv | 85 ++++++++
 rtl/instruction_dump_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/instruction_dump_tx_pkg.sv
// -----------------------------------------------------------------------------
// instruction_dump_tx_pkg
// Shared definitions for the instruction-memory UART dump path and the
// matching UART receiver side:
//   DEFAULT_CLKS_PER_BAUD : clocks per UART bit (100 MHz / 115200)
//   DEFAULT_LAST_ADDR     : final word address of a full dump
//   dump_state_t          : dump FSM state encoding
// -----------------------------------------------------------------------------
package instruction_dump_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BAUD = 868;
    localparam int DEFAULT_LAST_ADDR     = 255;

    // Start bit + 8 data bits + stop bit.
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        SEND_HI = 3'd2,
        WAIT_HI = 3'd3,
        SEND_LO = 3'd4,
        WAIT_LO = 3'd5,
        DONE    = 3'd6
    } dump_state_t;

endpackage

// File: rtl/txuartlite.sv
// -----------------------------------------------------------------------------
// txuartlite
// Minimal 8N1 UART transmitter, LSB first, line idles high.
// A write accepted while idle starts a frame on the next cycle; each bit
// (start, 8 data, stop) is held for exactly CLKS_PER_BAUD cycles, so a frame
// lasts UART_FRAME_BITS*CLKS_PER_BAUD cycles. o_busy drops on the same edge
// the stop bit ends.
// Ports:
//   i_clk      : system clock, rising edge
//   i_reset    : synchronous active-high reset; line returns high immediately
//   i_wr       : one-cycle write strobe (ignored while busy)
//   i_data     : byte to send
//   o_busy     : frame in progress
//   o_uart_tx  : serial output
// -----------------------------------------------------------------------------
module txuartlite
    import instruction_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_uart_tx
);

    localparam int CNT_W = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BAUD - 1);
    localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);

    logic             busy_q, busy_d;
    logic             tx_q, tx_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    // Remaining bits to shift out: data LSB first, stop bit on top.
    logic [8:0]       shreg_q, shreg_d;

    always_comb begin
        busy_d     = busy_q;
        tx_d       = tx_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        if (!busy_q) begin
            if (i_wr) begin
                busy_d     = 1'b1;
                tx_d       = 1'b0;
                shreg_d    = {1'b1, i_data};
                bit_idx_d  = 4'd0;
                baud_cnt_d = CNT_RELOAD;
            end
        end else if (baud_cnt_q != '0) begin
            baud_cnt_d = baud_cnt_q - 1'b1;
        end else if (bit_idx_q == LAST_BIT) begin
            // Stop bit complete; line is already high.
            busy_d = 1'b0;
        end else begin
            tx_d       = shreg_q[0];
            shreg_d    = {1'b1, shreg_q[8:1]};
            bit_idx_d  = bit_idx_q + 4'd1;
            baud_cnt_d = CNT_RELOAD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q     <= 1'b0;
            tx_q       <= 1'b1;
            baud_cnt_q <= '0;
            bit_idx_q  <= 4'd0;
        end else begin
            busy_q     <= busy_d;
            tx_q       <= tx_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
        end
        shreg_q <= shreg_d;
    end

    assign o_busy    = busy_q;
    assign o_uart_tx = tx_q;

endmodule

// File: rtl/instruction_dump_tx.sv
// -----------------------------------------------------------------------------
// instruction_dump_tx
// Streams instruction memory words 0..LAST_ADDR out over UART, two bytes per
// word, high byte first.
// Ports:
//   CLK          : system clock, rising edge
//   RST          : synchronous active-high reset (wins over start)
//   start        : one-cycle dump request, ignored while busy
//   rd_addr      : word address to the memory read port
//   rd_data      : word returned combinationally for rd_addr
//   UART_RXD_OUT : serial TX line, 8N1, idle high
//   busy         : dump in progress
//   dump_done    : one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module instruction_dump_tx
    import instruction_dump_tx_pkg::*;
#(
    parameter int         CLKS_PER_BAUD = DEFAULT_CLKS_PER_BAUD,
    parameter logic [7:0] LAST_ADDR     = 8'(DEFAULT_LAST_ADDR)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    output logic [7:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic        UART_RXD_OUT,
    output logic        busy,
    output logic        dump_done
);

    dump_state_t state_q, state_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic [15:0] word_q, word_d;

    logic       tx_wr;
    logic [7:0] tx_data;
    logic       tx_busy;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        word_d    = word_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d = 8'd0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                word_d  = rd_data;
                state_d = SEND_HI;
            end
            SEND_HI: state_d = WAIT_HI;
            WAIT_HI: begin
                if (!tx_busy) state_d = SEND_LO;
            end
            SEND_LO: state_d = WAIT_LO;
            WAIT_LO: begin
                if (!tx_busy) begin
                    // Stop at LAST_ADDR so the address never wraps mid-dump.
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + 8'd1;
                        state_d   = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            rd_addr_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
        end
        word_q <= word_d;
    end

    assign tx_wr   = (state_q == SEND_HI) || (state_q == SEND_LO);
    assign tx_data = (state_q == SEND_LO) ? word_q[7:0] : word_q[15:8];

    txuartlite #(
        .CLKS_PER_BAUD(CLKS_PER_BAUD)
    ) u_tx (
        .i_clk     (CLK),
        .i_reset   (RST),
        .i_wr      (tx_wr),
        .i_data    (tx_data),
        .o_busy    (tx_busy),
        .o_uart_tx (UART_RXD_OUT)
    );

    assign rd_addr   = rd_addr_q;
    // busy covers FETCH..WAIT_LO; it is already low in the DONE cycle.
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign dump_done = (state_q == DONE);

endmodule
